// File: rtl/sopc_bus_arbiter.sv
// sopc_bus_arbiter: round-robin arbiter for the shared SoPC slave bus.
// Serialises single-beat transactions; a watchdog errors out hung slaves.
module sopc_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*AW-1:0]     m_addr,
    input  logic [NUM_MASTERS*DW-1:0]     m_wdata,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic                          m_err,
    output logic [DW-1:0]                 m_rdata,
    output logic                          s_req,
    output logic                          s_we,
    output logic [AW-1:0]                 s_addr,
    output logic [DW-1:0]                 s_wdata,
    output logic [DW/8-1:0]               s_wstrb,
    input  logic                          s_ack,
    input  logic                          s_err,
    input  logic [DW-1:0]                 s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TW-1:0]   wd_q, wd_d;

    logic            win_vld;
    logic [IW-1:0]   win_id;
    logic [IW-1:0]   cand;
    int unsigned     idx;

    // Round robin: first requester at or above last+1, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx  = (int'(last_q) + k) % NUM_MASTERS;
            cand = IW'(idx);
            if (!win_vld && m_req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Next-state logic: grant in IDLE, wait for ack or watchdog in ACCESS.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ACCESS;
                    last_d  = win_id;
                    gid_d   = win_id;
                    we_d    = m_we[win_id];
                    addr_d  = m_addr[win_id*AW +: AW];
                    wdata_d = m_wdata[win_id*DW +: DW];
                    wstrb_d = m_wstrb[win_id*SW +: SW];
                    wd_d    = '0;
                end
            end
            ACCESS: begin
                if (s_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : s_rdata;
                    err_d   = s_err;
                end else if (TIMEOUT != 0 && wd_q == TLIM) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_MASTERS - 1);
            gid_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign s_req    = (state_q == ACCESS);
    assign busy     = (state_q != IDLE);
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;
    assign grant_id = gid_q;
    assign m_rdata  = rdata_q;
    assign m_err    = (state_q == RESP) && err_q;
    assign m_ack    = (state_q == RESP)
                    ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << gid_q)
                    : '0;

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// tb_sopc_bus_arbiter: scoreboard bench for sopc_bus_arbiter.
// Slave model and ack monitor run once per cycle on the falling edge.
module tb_sopc_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_we;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*DW/8-1:0] m_wstrb;
    logic [N-1:0]      m_ack;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic              s_ack;
    logic              s_err;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        grant_id;
    logic              busy;

    sopc_bus_arbiter #(
        .NUM_MASTERS(N),
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_ack(m_ack),
        .m_err(m_err),
        .m_rdata(m_rdata),
        .s_req(s_req),
        .s_we(s_we),
        .s_addr(s_addr),
        .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_ack(s_ack),
        .s_err(s_err),
        .s_rdata(s_rdata),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          prev_ack = -1;
    bit          chk_gap = 1'b0;
    int          slv_lat = 1;
    bit          slv_fix = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    bit          late_ack = 1'b0;
    int          scnt = 0;
    int          last_len = 0;
    logic [N-1:0] hold = '0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] rd, input logic er);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = er;
        sbq.push_back(e);
    endtask

    task automatic set_m(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        m_we[i]           = we;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = wd;
        m_wstrb[i*4 +: 4] = ws;
    endtask

    // One clock: monitor acks, then model the slave for the next edge.
    task automatic cyc();
        exp_t         e;
        logic [N-1:0] ea;
        @(negedge clk);
        cyc_n++;
        if (m_ack != '0) begin
            chk("ack_onehot", 64'($onehot(m_ack)), 1);
            if (sbq.size() == 0) begin
                chk("unexp_ack", m_ack, 0);
            end else begin
                e  = sbq.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                chk("ack_id", m_ack, ea);
                chk("ack_rdata", m_rdata, e.rdata);
                chk("ack_err", m_err, e.err);
                if (chk_gap && prev_ack >= 0)
                    chk("ack_gap", 64'(cyc_n - prev_ack), 3);
                prev_ack = cyc_n;
            end
            m_req = m_req & (~m_ack | hold);
        end else begin
            chk("err_no_ack", m_err, 0);
        end
        if (s_req) begin
            scnt++;
            if (scnt == 1) begin
                cap_we    = s_we;
                cap_addr  = s_addr;
                cap_wdata = s_wdata;
                cap_wstrb = s_wstrb;
            end else begin
                chk("stab_we", s_we, cap_we);
                chk("stab_addr", s_addr, cap_addr);
                chk("stab_wdata", s_wdata, cap_wdata);
                chk("stab_wstrb", s_wstrb, cap_wstrb);
            end
            s_ack   = (slv_lat != 0) && (scnt == slv_lat);
            s_rdata = slv_fix ? slv_rdata : (s_addr ^ K);
            s_err   = slv_err;
        end else begin
            if (scnt != 0) last_len = scnt;
            scnt    = 0;
            s_ack   = late_ack;
            s_rdata = '0;
            s_err   = 1'b0;
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int i;
        i = 0;
        while (sbq.size() != 0 && i < budget) begin
            cyc();
            i++;
        end
        chk(tag, 64'(sbq.size()), 0);
        sbq.delete();
    endtask

    task automatic chk_rst();
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_s_req", s_req, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_wstrb", s_wstrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
    endtask

    initial begin
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdata = '0;
        cyc();
        cyc();
        chk_rst();
        rst_n = 1'b1;
        cyc();

        // Single read, slave acks in 2nd ACCESS cycle
        set_m(1, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        slv_lat   = 2;
        slv_fix   = 1'b1;
        slv_rdata = 32'hDEAD_BEEF;
        push(1, 32'hDEAD_BEEF, 1'b0);
        m_req[1] = 1'b1;
        wait_empty("rd_done", 20);
        chk("rd_len", 64'(last_len), 2);
        chk("rd_addr", s_addr, 32'h2000_0010);
        chk("rd_grant", grant_id, 1);

        // Write path returns zero read data
        set_m(2, 1'b1, 32'h4000_0000, 32'h1234_5678, 4'b0011);
        slv_lat   = 3;
        slv_rdata = 32'hFFFF_FFFF;
        push(2, 32'h0, 1'b0);
        m_req[2] = 1'b1;
        wait_empty("wr_done", 20);
        chk("wr_len", 64'(last_len), 3);
        chk("wr_we", s_we, 1);
        chk("wr_addr", s_addr, 32'h4000_0000);
        chk("wr_wdata", s_wdata, 32'h1234_5678);
        chk("wr_wstrb", s_wstrb, 4'b0011);

        // Slave error, master address changed during ACCESS
        set_m(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        slv_fix = 1'b0;
        slv_err = 1'b1;
        push(0, 32'h0000_0100 ^ K, 1'b1);
        m_req[0] = 1'b1;
        cyc();
        cyc();
        m_addr[0 +: AW] = 32'h0000_0BAD;
        wait_empty("serr_done", 20);
        chk("serr_addr", s_addr, 32'h0000_0100);
        slv_err = 1'b0;

        // Watchdog on a silent slave, then a late ack
        set_m(1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        slv_lat = 0;
        push(1, 32'h0, 1'b1);
        m_req[1] = 1'b1;
        wait_empty("wd_done", 30);
        chk("wd_len", 64'(last_len), TO);
        cyc();
        cyc();
        late_ack = 1'b1;
        cyc();
        late_ack = 1'b0;
        cyc();
        cyc();
        chk("late_busy", busy, 0);

        // Next request after timeout proceeds normally
        set_m(2, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        slv_lat = 1;
        push(2, 32'h0000_0500 ^ K, 1'b0);
        m_req[2] = 1'b1;
        wait_empty("post_wd_done", 20);
        chk("post_wd_len", 64'(last_len), 1);

        // Ack in the same cycle as the timeout wins
        set_m(0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
        slv_lat = TO;
        push(0, 32'h0000_0600 ^ K, 1'b0);
        m_req[0] = 1'b1;
        wait_empty("race_done", 30);
        chk("race_len", 64'(last_len), TO);

        // Reset while in ACCESS
        set_m(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
        slv_lat = 0;
        m_req[1] = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("pre_rst_sreq", s_req, 1);
        rst_n = 1'b0;
        m_req = '0;
        cyc();
        cyc();
        chk_rst();
        rst_n = 1'b1;

        // Fairness: all masters continuous, zero-wait slave
        set_m(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0000_1100, 32'h0, 4'h0);
        set_m(2, 1'b0, 32'h0000_1200, 32'h0, 4'h0);
        slv_lat = 1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                push(i, (32'h0000_1000 + 32'(i) * 32'h100) ^ K, 1'b0);
        hold     = '1;
        m_req    = '1;
        prev_ack = -1;
        chk_gap  = 1'b1;
        wait_empty("fair_done", 40);
        chk_gap = 1'b0;
        m_req   = '0;
        hold    = '0;
        cyc();
        cyc();
        cyc();
        chk("fair_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sopc_bus_arbiter.md
# sopc_bus_arbiter

Round-robin arbiter and sequencer for the shared peripheral/memory slave bus of `riscv_sopc`. It lets up to NUM_MASTERS requesters share one single-beat slave port, for example the core instruction port, the core data port and a debug/DMA master. It serialises transactions, forwards the winner's command to the slave, and routes the response back. A bus watchdog converts a hung slave into an error response.

## Interface
- NUM_MASTERS, 3: number of requesters (2..8).
- AW, 32: address width.
- DW, 32: data width (multiple of 8).
- TIMEOUT, 255: maximum cycles `s_req` may stay high without `s_ack`; 0 disables the watchdog.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master request level; held until that master's `m_ack`.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_addr  in  NUM_MASTERS*AW  packed addresses; master i occupies [i*AW +: AW].
- m_wdata  in  NUM_MASTERS*DW  packed write data.
- m_wstrb  in  NUM_MASTERS*DW/8  packed byte strobes.
- m_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_err  out  1  error flag, valid with `m_ack`.
- m_rdata  out  DW  read data, shared by all masters, valid with `m_ack`.
- s_req, s_we  out  1  slave command valid and write enable.
- s_addr  out  AW  registered winner address.
- s_wdata  out  DW  registered winner write data.
- s_wstrb  out  DW/8  registered winner byte strobes.
- s_ack  in  1  slave completion; sampled only while `s_req`=1.
- s_err  in  1  slave error, valid with `s_ack`.
- s_rdata  in  DW  slave read data, valid with `s_ack`.
- grant_id  out  $clog2(NUM_MASTERS)  index of the current or last owner.
- busy  out  1  high in ACCESS and RESP.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE.
- **IDLE**
  - If `m_req` is nonzero, pick the winner by round robin: the first requester at or above `last+1`, wrapping modulo NUM_MASTERS.
  - Latch the winner's we/addr/wdata/wstrb into the `s_*` registers, set `grant_id` and `last`, go to ACCESS.
- **ACCESS**
  - `s_req`=1. Command registers stay frozen; later changes on the master's inputs are ignored.
  - On `s_ack`: capture `s_rdata` and `s_err`, drop `s_req`, go to RESP.
  - Watchdog: counter clears on entry to ACCESS and increments each ACCESS cycle without `s_ack`. When it reaches TIMEOUT (TIMEOUT≠0), drop `s_req`, load rdata=0 and err=1, go to RESP.
  - `s_ack` and timeout in the same cycle: `s_ack` wins.
- **RESP**
  - `m_ack[grant_id]`=1 for exactly one cycle, with `m_rdata` and `m_err` valid.
  - Go to IDLE. No arbitration happens in RESP: the acknowledged master's `m_req` is still high this cycle.
- Master drops `m_req` mid-transaction: the slave transaction still completes and `m_ack` still pulses; the master ignores it. There is no abort.
- `s_ack` while `s_req`=0 (late ack after a timeout, or spurious): ignored, with no state change.
- Writes return `m_rdata`=0.
- Outside RESP, `m_ack`=0 and `m_err`=0. `m_rdata` holds its last value.
- Reset mid-operation: `rst_n` low immediately returns the block to IDLE and clears every output. Any in-flight transaction is lost without an ack.

## Timing
- Reset values:
  - `m_ack`=0, `m_err`=0, `m_rdata`=0.
  - `s_req`=0, `s_we`=0, `s_addr`=0, `s_wdata`=0, `s_wstrb`=0.
  - `busy`=0, `grant_id`=0.
  - `last`=NUM_MASTERS-1, so master 0 has first priority.
- `m_req` sampled in IDLE at cycle 0 → `s_req`=1 in cycle 1.
- `s_ack` in cycle k (k≥1) → `m_ack` in cycle k+1 → IDLE in cycle k+2.
- Zero-wait slave: 3 cycles per transaction. Continuous requesters are served back-to-back with no extra bubble.
- Timeout: `s_req` is high for exactly TIMEOUT cycles, then `m_ack` and `m_err` pulse in the next cycle.
- All outputs are registered. There are no combinational paths from `m_*` or `s_*` inputs to outputs.

## Test plan
- **Single read:** master 1 reads addr 0x2000_0010; slave acks in its 2nd ACCESS cycle with rdata 0xDEAD_BEEF.
  - Expect `s_req` high for 2 cycles, `s_addr`=0x2000_0010.
  - Expect `m_ack`=3'b010 one cycle after `s_ack`, `m_rdata`=0xDEAD_BEEF, `m_err`=0.
- **Fairness:** all 3 masters request continuously with a zero-wait slave.
  - Expect grant order 0,1,2,0,1,2.
  - Expect one `m_ack` every 3 cycles.
  - Expect no master acked twice before the others are acked once.
- **Write path:** master 2 writes 0x1234_5678 with wstrb 4'b0011 to 0x4000_0000.
  - Expect the `s_*` signals to match exactly and stay stable while `s_req`=1.
  - Expect `m_ack[2]`, with `m_rdata`=0.
- **Watchdog:** TIMEOUT=8, slave never acks.
  - Expect `s_req` high for 8 cycles, then `m_ack` and `m_err`=1 with `m_rdata`=0.
  - A late `s_ack` 3 cycles later is ignored.
  - The next request proceeds normally.
- **Slave error / input stability:** `s_err`=1 with `s_ack` → `m_err`=1.
  - Changing master 0's `m_addr` during ACCESS leaves `s_addr` unchanged.
- **Reset mid-ACCESS:** assert `rst_n`=0 for 2 cycles while `s_req`=1.
  - Expect all outputs at reset values and no `m_ack`.
  - After release, master 0 is granted first when all masters request.
